spi_slave_if: RTL
=================

Name: spi_slave_if

Overview:
SPI responder (slave) end of the team's SPI link. Receives SCLK/CS/MOSI from an external master and drives MISO. Matches the master's bit timing: MISO changes on SCLK rising edge, MOSI is sampled on SCLK falling edge, MSB first, 8-bit words. Presents received bytes and accepts transmit bytes to local logic through a simple valid/ready interface.

Parameters:
DATA_WIDTH, 8, bits per transaction word
SYNC_STAGES, 2, synchronizer flops on sclk_i/cs_i/mosi_i (min 2)
DUMMY_WORD, 8'hFF, word shifted out when no tx word is buffered
CNT_WIDTH, 10, width of the completed-word counter

Ports:
clk_i  in  1  system clock; the SCLK frequency is at most clk_i/8
rst_i  in  1  asynchronous, active-low reset
sclk_i  in  1  SPI clock from master, CPOL=0, asynchronous to clk_i
cs_i  in  1  chip select from master, active low
mosi_i  in  1  serial data from master
miso_o  out  1  serial data to master
miso_oe_o  out  1  high while selected; pad tri-state control
tx_data_i  in  DATA_WIDTH  word to send in a later transaction
tx_valid_i  in  1  tx_data_i is valid
tx_ready_o  out  1  tx holding register empty
rx_data_o  out  DATA_WIDTH  last complete received word
rx_valid_o  out  1  one-cycle pulse when rx_data_o updates
tx_underrun_o  out  1  one-cycle pulse when DUMMY_WORD is loaded
abort_o  out  1  one-cycle pulse when CS deasserts mid-word
word_cnt_o  out  CNT_WIDTH  words completed in the current CS frame

Behaviour:
- Reset (async, rst_i=0): miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, abort_o=0, word_cnt_o=0. Synchronizers reset to sclk=0, cs=1. FSM goes to IDLE. Tx holding register is cleared.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last synchronized stage with one extra flop. mosi uses the same depth, so data stays aligned with the sclk edge.
- Tx holding register: a write happens when tx_valid_i && tx_ready_o. On the next cycle, tx_ready_o=0. tx_ready_o returns to 1 in the cycle after the word is copied into the shift register.
- FSM states:
  - IDLE: cs high; miso_oe_o=0. On cs falling edge, go to LOAD and clear word_cnt_o.
  - LOAD (1 cycle): if the holding register is full, copy it to tx_shift. Otherwise copy DUMMY_WORD and pulse tx_underrun_o. Clear bit_cnt. Go to SHIFT.
  - SHIFT: on each sclk rising edge, miso_o takes tx_shift MSB and tx_shift shifts left. On each sclk falling edge, rx_shift takes {rx_shift[DATA_WIDTH-2:0], mosi} and bit_cnt increments. When the falling edge with bit_cnt==DATA_WIDTH-1 occurs, go to STORE.
  - STORE (1 cycle): rx_data_o <= rx_shift; pulse rx_valid_o; word_cnt_o++. Go to LOAD. The next word starts immediately while CS stays low.
- Latency: a pin sclk edge is acted on SYNC_STAGES+1 clk_i cycles later. rx_valid_o asserts SYNC_STAGES+2 cycles after the final pin falling edge.
- miso_oe_o=1 in every state except IDLE.
- miso_o holds its value between rising edges. It is 0 in IDLE and before the first rising edge of a frame.
- CS deassert in SHIFT with bit_cnt>0, or with any rising edge seen: pulse abort_o, discard rx_shift, do not update rx_data_o, go to IDLE. A word already moved from holding to shift is lost.
- CS deassert in LOAD, STORE, or SHIFT before any edge: go to IDLE with no abort_o. STORE always completes its rx update first.
- CS edge and sclk edge in the same cycle: CS takes priority.
- word_cnt_o wraps modulo 2^CNT_WIDTH. Once a frame ends, it holds its value until the next CS falling edge.
- Simultaneous tx write and LOAD copy in the same cycle: the copy uses the old register contents (empty means DUMMY_WORD). The new word stays buffered and tx_ready_o=0.

Decomposition:
- Add to spi_pkg:
  - slave_state_t enum {IDLE, LOAD, SHIFT, STORE}, logic [1:0]
  - constants SPI_WORD_W=8 and SPI_DUMMY=8'hFF (parameter defaults)
- One sub-module, spi_sync_edge: parameterized SYNC_STAGES synchronizer with rise_o/fall_o/level_o outputs. Instantiate it for sclk and cs; mosi uses level only.

Test Plan:
- Preload tx=8'hA5, CS low, master sends 8'h3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; one rx_valid_o pulse with rx_data_o=8'h3C; word_cnt_o=1; tx_ready_o back to 1.
- No tx preload, master sends 8'h81 -> tx_underrun_o pulses in LOAD, MISO=8'hFF, rx_data_o=8'h81.
- Burst of 3 words under one CS (0x11,0x22,0x33), tx 0xC1,0xC2 then none -> rx_valid_o x3 with values in order; MISO 0xC1,0xC2,0xFF; word_cnt_o=3.
- CS high after 5 falling edges -> abort_o one pulse; rx_data_o keeps previous value; no rx_valid_o; state IDLE; next frame works normally.
- Assert rst_i=0 mid-SHIFT for 1 cycle (asynchronous) -> all outputs at reset values immediately; after release, cs low and the next full word receives correctly.
- tx_valid_i held high with tx_ready_o=0 -> no overwrite of the buffered word; new word accepted only after the LOAD copy.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI link blocks.
package spi_pkg;

    localparam int         SPI_WORD_W = 8;
    localparam logic [7:0] SPI_DUMMY  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } slave_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with edge detection
// against one extra flop behind the last synchronizer stage.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer chain and keep one delayed copy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~prev_q;
    assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder, CPOL=0: MISO launched on SCLK rise, MOSI captured on SCLK
// fall, MSB first. Local side sees a one-word tx holding register and an
// rx word with a valid pulse.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_WORD_W,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DUMMY_WORD  = SPI_DUMMY,
    parameter int                    CNT_WIDTH   = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  cs_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  abort_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o
);

    localparam int                BCW      = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0]    LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    // mosi shares the sclk chain depth so the sampled bit lines up with the edge.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_i),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    slave_state_t          state_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BCW-1:0]        bit_cnt;
    logic                  seen_rise;

    logic tx_wr, load_copy;

    assign tx_ready_o = ~hold_full;
    assign tx_wr      = tx_valid_i & tx_ready_o;
    // LOAD abandoned by CS deassert leaves the buffered word in place.
    assign load_copy  = (state_q == LOAD) & ~cs_rise & hold_full;
    assign miso_oe_o  = (state_q != IDLE);

    // Tx holding register; a write can only land while empty, so it never
    // collides with a copy-out in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (tx_wr) begin
            hold_q    <= tx_data_i;
            hold_full <= 1'b1;
        end else if (load_copy) begin
            hold_full <= 1'b0;
        end
    end

    // Framing FSM with shift registers; CS deassert outranks any sclk edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            seen_rise     <= 1'b0;
            miso_o        <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            abort_o       <= 1'b0;
            word_cnt_o    <= '0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            abort_o       <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_o <= 1'b0;
                    if (cs_fall) begin
                        state_q    <= LOAD;
                        word_cnt_o <= '0;
                    end
                end
                LOAD: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_o  <= 1'b0;
                    end else begin
                        tx_shift      <= hold_full ? hold_q : DUMMY_WORD;
                        tx_underrun_o <= ~hold_full;
                        bit_cnt       <= '0;
                        seen_rise     <= 1'b0;
                        state_q       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        abort_o  <= seen_rise | (bit_cnt != '0);
                        rx_shift <= '0;
                        miso_o   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (sclk_rise) begin
                        miso_o    <= tx_shift[DATA_WIDTH-1];
                        tx_shift  <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        seen_rise <= 1'b1;
                    end else if (sclk_fall) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_lvl};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state_q <= STORE;
                    end
                end
                STORE: begin
                    rx_data_o  <= rx_shift;
                    rx_valid_o <= 1'b1;
                    word_cnt_o <= word_cnt_o + 1'b1;
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_o  <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
